abd_pcim_rd_master: RTL

- AXI4 read master on the PCIM interface; the initiator counterpart to the PCIS read slave path.
- Accepts internal AmorphOS read requests (64B-aligned address, beat count 1..64, tag) and issues AXI AR bursts, splitting any burst that crosses a 4KB boundary.
- Collects R beats and returns them, in order, as tagged 512-bit response beats to AmorphOS.

---
 rtl/abd_pcim_rd_master.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/abd_pcim_rd_master.sv
// AXI4 read master for the PCIM interface: turns tagged internal read requests into
// 4KB-safe AR bursts and returns the R beats in order as tagged response beats.
module abd_pcim_rd_master #(
   parameter int          LOG_DEPTH = 4,
   parameter logic [5:0]  AXI_ID    = 6'd0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [63:0]          req_addr,
   input  logic [6:0]           req_beats,
   input  logic [7:0]           req_tag,
   output logic [5:0]           arid,
   output logic [63:0]          araddr,
   output logic [7:0]           arlen,
   output logic [2:0]           arsize,
   output logic                 arvalid,
   input  logic                 arready,
   input  logic [5:0]           rid,
   input  logic [511:0]         rdata,
   input  logic [1:0]           rresp,
   input  logic                 rlast,
   input  logic                 rvalid,
   output logic                 rready,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [511:0]         resp_data,
   output logic [7:0]           resp_tag,
   output logic                 resp_last,
   output logic                 resp_err,
   output logic [LOG_DEPTH:0]   outstanding_count,
   output logic [1:0]           err_sticky
);

   localparam int                DEPTH    = 1 << LOG_DEPTH;
   localparam logic [LOG_DEPTH:0] FULL_CNT = (LOG_DEPTH + 1)'(DEPTH);

   typedef enum logic {IDLE, ISSUE} state_t;

   typedef struct packed {
      logic [7:0] tag;
      logic [6:0] seg;
      logic       is_final;
   } entry_t;

   state_t                state;
   logic [63:0]           cur_addr;
   logic [6:0]            beats_left;
   logic [7:0]            cur_tag;

   entry_t                fifo_mem [DEPTH];
   logic [LOG_DEPTH-1:0]  wr_ptr;
   logic [LOG_DEPTH-1:0]  rd_ptr;
   logic [5:0]            beat_cnt;
   entry_t                head;

   logic [6:0]            space;
   logic [6:0]            seg;
   logic                  seg_final;
   logic                  fifo_empty;
   logic                  seg_end;
   logic                  ar_fire;
   logic                  r_fire;
   logic                  pop;
   logic [LOG_DEPTH:0]    cnt_next;
   logic                  unused_addr_bits;

   // Low address bits are discarded on request capture; requests are 64B aligned.
   assign unused_addr_bits = ^req_addr[5:0];

   // Segment length: stop at the next 4KB boundary. 7-bit math makes an aligned start yield 64.
   assign space     = 7'd64 - {1'b0, cur_addr[11:6]};
   assign seg       = (beats_left < space) ? beats_left : space;
   assign seg_final = (seg == beats_left);

   assign arid   = AXI_ID;
   assign araddr = cur_addr;
   assign arlen  = {1'b0, seg - 7'd1};
   assign arsize = 3'b110;

   assign fifo_empty = (outstanding_count == '0);
   assign head       = fifo_mem[rd_ptr];
   assign seg_end    = ({1'b0, beat_cnt} == (head.seg - 7'd1));

   assign rready     = resp_ready && !fifo_empty;
   assign resp_valid = rvalid && !fifo_empty;
   assign resp_data  = rdata;
   assign resp_tag   = head.tag;
   assign resp_last  = head.is_final && seg_end;
   assign resp_err   = (rresp != 2'b00);

   assign ar_fire = arvalid && arready;
   assign r_fire  = rvalid && rready;
   assign pop     = r_fire && seg_end;

   // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
   always_comb begin
      cnt_next = outstanding_count;
      if (ar_fire && !pop)
         cnt_next = outstanding_count + 1'b1;
      else if (!ar_fire && pop)
         cnt_next = outstanding_count - 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_ready  <= 1'b0;
         arvalid    <= 1'b0;
         cur_addr   <= '0;
         beats_left <= '0;
         cur_tag    <= '0;
      end else begin
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  cur_addr   <= {req_addr[63:6], 6'b0};
                  beats_left <= req_beats;
                  cur_tag    <= req_tag;
                  req_ready  <= 1'b0;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (ar_fire) begin
                  cur_addr   <= cur_addr + {51'b0, seg, 6'b0};
                  beats_left <= beats_left - seg;
                  if (seg_final) begin
                     arvalid   <= 1'b0;
                     req_ready <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     arvalid <= (cnt_next < FULL_CNT);
                  end
               end else if (!arvalid) begin
                  // Credit gates only the rising edge; a raised arvalid waits for arready.
                  arvalid <= (cnt_next < FULL_CNT);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         beat_cnt          <= '0;
         outstanding_count <= '0;
         err_sticky        <= 2'b00;
      end else begin
         outstanding_count <= cnt_next;
         if (ar_fire)
            wr_ptr <= wr_ptr + 1'b1;
         if (r_fire) begin
            if (seg_end) begin
               rd_ptr   <= rd_ptr + 1'b1;
               beat_cnt <= '0;
            end else begin
               beat_cnt <= beat_cnt + 1'b1;
            end
            // The beat count stays authoritative; rlast and rid only feed the error flag.
            if ((rlast != seg_end) || (rid != AXI_ID))
               err_sticky[1] <= 1'b1;
            if (rresp != 2'b00)
               err_sticky[0] <= 1'b1;
         end
      end
   end

   // NOTE: the bookkeeping storage has no reset; the pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (ar_fire)
         fifo_mem[wr_ptr] <= '{tag: cur_tag, seg: seg, is_final: seg_final};
   end

endmodule
